// File: rtl/uart_rx_fifo_if.sv
// Host-side read port of the UART receive FIFO.
//   rd_data  : {overrun_tag, framing_tag, byte} at the FIFO head
//   rd_valid : FIFO holds at least one entry
//   rd_ready : host pop request; a pop happens when rd_valid & rd_ready
// slave  : FIFO side (drives rd_data/rd_valid)
// master : host side (drives rd_ready)
interface uart_rx_fifo_if;
    logic [9:0] rd_data;
    logic       rd_valid;
    logic       rd_ready;

    modport slave (
        output rd_data,
        output rd_valid,
        input  rd_ready
    );

    modport master (
        input  rd_data,
        input  rd_valid,
        output rd_ready
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: drains the receiver's single-byte holding buffer into a
// DEPTH-entry first-word-fall-through FIFO, tagging each byte with the
// receiver's overrun and framing-error status at capture time.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   rx_data             byte from the receiver holding buffer
//   rx_data_valid       receiver holding buffer full
//   rx_overrun          receiver overrun indication (tag bit 9)
//   rx_framing_err      receiver sticky framing error (tag bit 8)
//   host_ready          one-cycle unload pulse back to the receiver
//   clear_framing_err   one-cycle clear pulse back to the receiver
//   rd                  host read port (rd_data / rd_valid / rd_ready)
//   count               occupancy, 0..DEPTH
//   full                count == DEPTH
//   irq_level           count >= THRESH
//   overflow_seen       sticky: some captured entry carried overrun_tag=1
//   clear_status        clears overflow_seen (a same-cycle set wins)
module uart_rx_fifo #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned AW     = $clog2(DEPTH),
    parameter int unsigned THRESH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    rx_data,
    input  logic          rx_data_valid,
    input  logic          rx_overrun,
    input  logic          rx_framing_err,
    output logic          host_ready,
    output logic          clear_framing_err,
    uart_rx_fifo_if.slave rd,
    output logic [AW:0]   count,
    output logic          full,
    output logic          irq_level,
    output logic          overflow_seen,
    input  logic          clear_status
);

    localparam int unsigned CW = AW + 1;

    typedef struct packed {
        logic       overrun;
        logic       framing;
        logic [7:0] data;
    } entry_t;

    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_ACK  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t         state;
    entry_t         mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           wr_en;
    logic           pop;
    entry_t         wr_entry;

    // Capture only from WAIT; ACK/HOLD give the receiver time to unload/reload.
    assign wr_en    = (state == S_WAIT) && rx_data_valid && !full;
    assign pop      = rd.rd_valid && rd.rd_ready;
    assign wr_entry = '{overrun: rx_overrun, framing: rx_framing_err, data: rx_data};

    // Status derived from the registered occupancy counter.
    assign full        = (count == CW'(DEPTH));
    assign irq_level   = (count >= CW'(THRESH));
    assign rd.rd_valid = (count != '0);
    assign rd.rd_data  = mem[rd_ptr];

    // Capture handshake FSM; outputs registered so they are high exactly in ACK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= S_WAIT;
            host_ready        <= 1'b0;
            clear_framing_err <= 1'b0;
        end else begin
            case (state)
                S_WAIT: begin
                    if (wr_en) begin
                        state             <= S_ACK;
                        host_ready        <= 1'b1;
                        clear_framing_err <= 1'b1;
                    end
                end
                S_ACK: begin
                    state             <= S_HOLD;
                    host_ready        <= 1'b0;
                    clear_framing_err <= 1'b0;
                end
                S_HOLD: begin
                    state <= S_WAIT;
                end
                default: begin
                    state             <= S_WAIT;
                    host_ready        <= 1'b0;
                    clear_framing_err <= 1'b0;
                end
            endcase
        end
    end

    // Storage: contents need no reset, they are only visible while count != 0.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    // Pointers wrap naturally at DEPTH since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    // Occupancy: unchanged when a write and a pop coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (wr_en && !pop) begin
            count <= count + CW'(1);
        end else if (!wr_en && pop) begin
            count <= count - CW'(1);
        end
    end

    // Sticky overrun flag; a capture with overrun beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_seen <= 1'b0;
        end else if (wr_en && rx_overrun) begin
            overflow_seen <= 1'b1;
        end else if (clear_status) begin
            overflow_seen <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized scoreboard bench for uart_rx_fifo. A receiver process presents
// bytes from tx_q and reloads after each host_ready; a host process drives
// rd_ready; a negedge monitor keeps a queue-based reference of the FIFO and
// compares every DUT output each cycle.
module tb_uart_rx_fifo;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned THRESH = 8;

    logic          clk;
    logic          rst_n;
    logic [7:0]    rx_data;
    logic          rx_data_valid;
    logic          rx_overrun;
    logic          rx_framing_err;
    logic          host_ready;
    logic          clear_framing_err;
    logic [AW:0]   count;
    logic          full;
    logic          irq_level;
    logic          overflow_seen;
    logic          clear_status;

    uart_rx_fifo_if rd_if ();

    uart_rx_fifo #(
        .DEPTH  (DEPTH),
        .THRESH (THRESH)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .rx_data           (rx_data),
        .rx_data_valid     (rx_data_valid),
        .rx_overrun        (rx_overrun),
        .rx_framing_err    (rx_framing_err),
        .host_ready        (host_ready),
        .clear_framing_err (clear_framing_err),
        .rd                (rd_if),
        .count             (count),
        .full              (full),
        .irq_level         (irq_level),
        .overflow_seen     (overflow_seen),
        .clear_status      (clear_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Stimulus and reference-model state
    logic [9:0] tx_q[$];     // bytes waiting to be presented by the receiver
    logic [9:0] pend_q[$];   // presented, not yet captured
    logic [9:0] exp_q[$];    // reference FIFO contents
    int         cyc      = 0;
    int         last_cap = -10;
    bit         ovf_m    = 1'b0;
    bit         wrap_phase = 1'b0;
    int         rx_gap_max = 0;
    int         rd_mode  = 0;    // 0 idle, 1 always, 2 random, 3 one-shot
    int         shot_id  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Receiver model: holds one byte until acknowledged, then reloads.
    initial begin : receiver
        int gap;
        logic [9:0] e;
        gap = 0;
        rx_data_valid  = 1'b0;
        rx_data        = '0;
        rx_overrun     = 1'b0;
        rx_framing_err = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rx_data_valid && host_ready) begin
                rx_data_valid = 1'b0;
                gap = int'($urandom_range(0, rx_gap_max));
            end
            if (!rx_data_valid) begin
                if (gap > 0) begin
                    gap--;
                end else if (tx_q.size() > 0) begin
                    e = tx_q.pop_front();
                    {rx_overrun, rx_framing_err, rx_data} = e;
                    rx_data_valid = 1'b1;
                    pend_q.push_back(e);
                end
            end
        end
    end

    // Host model: drives rd_ready according to rd_mode.
    initial begin : host
        int last_shot;
        last_shot = 0;
        rd_if.rd_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rd_mode)
                1:       rd_if.rd_ready = 1'b1;
                2:       rd_if.rd_ready = 1'($urandom_range(0, 1));
                3: begin
                    rd_if.rd_ready = (shot_id != last_shot);
                    last_shot = shot_id;
                end
                default: rd_if.rd_ready = 1'b0;
            endcase
        end
    end

    // Monitor: compare outputs to the reference, then apply the upcoming edge.
    always @(negedge clk) begin : monitor
        logic [9:0] e;
        bit pop, cap;
        e = '0;
        if (!rst_n) begin
            check("rst_host_ready", host_ready, 0);
            check("rst_clear_framing_err", clear_framing_err, 0);
            check("rst_rd_valid", rd_if.rd_valid, 0);
            check("rst_count", count, 0);
            check("rst_full", full, 0);
            check("rst_irq_level", irq_level, 0);
            check("rst_overflow_seen", overflow_seen, 0);
            exp_q.delete();
            ovf_m    = 1'b0;
            last_cap = -10;
        end else begin
            check("host_ready", host_ready, int'(last_cap == cyc - 1));
            check("clear_framing_err", clear_framing_err, int'(last_cap == cyc - 1));
            check("rd_valid", rd_if.rd_valid, int'(exp_q.size() != 0));
            check("count", count, exp_q.size());
            check("full", full, int'(exp_q.size() == DEPTH));
            check("irq_level", irq_level, int'(exp_q.size() >= THRESH));
            check("overflow_seen", overflow_seen, int'(ovf_m));
            if (exp_q.size() != 0) check("rd_data", rd_if.rd_data, exp_q[0]);
            if (wrap_phase) check("wrap_count_le2", int'(count <= 2), 1);

            pop = (exp_q.size() != 0) && rd_if.rd_ready;
            cap = rx_data_valid && (exp_q.size() < DEPTH) && (cyc - last_cap >= 3);
            if (pop) void'(exp_q.pop_front());
            if (cap) begin
                if (pend_q.size() == 0) begin
                    check("pending_byte_present", 0, 1);
                end else begin
                    e = pend_q.pop_front();
                    exp_q.push_back(e);
                end
                last_cap = cyc;
            end
            if (cap && e[9]) ovf_m = 1'b1;
            else if (clear_status) ovf_m = 1'b0;
        end
        cyc++;
    end

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push_byte(input bit ov, input bit fe, input logic [7:0] d);
        tx_q.push_back({ov, fe, d});
    endtask

    task automatic pop_once();
        shot_id++;
        rd_mode = 3;
    endtask

    // Drain everything through the host port, bounded.
    task automatic drain(input string name);
        int n;
        n = 0;
        rd_mode = 1;
        while ((tx_q.size() != 0 || pend_q.size() != 0 || rx_data_valid || exp_q.size() != 0)
               && n < 600) begin
            wait_cycles(1);
            n++;
        end
        check(name, int'(n < 600), 1);
        rd_mode = 0;
        wait_cycles(2);
    endtask

    initial begin : main
        int n;
        rst_n        = 1'b0;
        clear_status = 1'b0;
        wait_cycles(3);
        rst_n = 1'b1;
        wait_cycles(2);

        // Single byte 0xA5
        push_byte(1'b0, 1'b0, 8'hA5);
        wait_cycles(5);
        check("a5_count", count, 1);
        check("a5_rd_valid", rd_if.rd_valid, 1);
        check("a5_rd_data", rd_if.rd_data, 10'h0A5);
        pop_once();
        wait_cycles(3);
        rd_mode = 0;
        check("a5_popped_count", count, 0);
        check("a5_popped_valid", rd_if.rd_valid, 0);

        // Fill to full with 0x00..0x0F; 0x10 must wait
        for (int i = 0; i <= 16; i++) push_byte(1'b0, 1'b0, 8'(i));
        wait_cycles(60);
        check("fill_count", count, 16);
        check("fill_full", full, 1);
        check("fill_irq", irq_level, 1);
        check("fill_no_ack", host_ready, 0);
        pop_once();
        wait_cycles(8);
        rd_mode = 0;
        check("refill_count", count, 16);
        drain("drain_fill");

        // Framing tag then a clean byte
        push_byte(1'b0, 1'b1, 8'h3C);
        push_byte(1'b0, 1'b0, 8'h77);
        wait_cycles(10);
        check("fe_head", rd_if.rd_data, 10'h13C);
        drain("drain_framing");

        // Overrun tag; clear_status coincident with a second overrun capture
        push_byte(1'b1, 1'b0, 8'h55);
        wait_cycles(6);
        check("ov_head", rd_if.rd_data, 10'h255);
        check("ov_seen", overflow_seen, 1);
        push_byte(1'b1, 1'b0, 8'h66);
        wait_cycles(1);
        clear_status = 1'b1;
        wait_cycles(1);
        clear_status = 1'b0;
        check("ov_set_beats_clear", overflow_seen, 1);
        wait_cycles(4);
        clear_status = 1'b1;
        wait_cycles(1);
        clear_status = 1'b0;
        check("ov_cleared", overflow_seen, 0);
        drain("drain_overrun");

        // Pointer wrap with pops concurrent to captures
        wrap_phase = 1'b1;
        rd_mode    = 1;
        for (int i = 0; i < 40; i++) push_byte(1'b0, 1'b0, 8'($urandom_range(0, 255)));
        drain("drain_wrap");
        wrap_phase = 1'b0;

        // Reset asserted during ACK
        push_byte(1'b0, 1'b0, 8'h81);
        push_byte(1'b0, 1'b0, 8'h82);
        n = 0;
        do begin
            wait_cycles(1);
            n++;
        end while (!host_ready && n < 20);
        check("ack_seen", int'(host_ready), 1);
        rst_n = 1'b0;
        #1;
        check("rst_ack_host_ready", host_ready, 0);
        check("rst_ack_count", count, 0);
        check("rst_ack_rd_valid", rd_if.rd_valid, 0);
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(5);
        check("post_rst_count", count, 1);
        check("post_rst_data", rd_if.rd_data, 10'h082);
        drain("drain_reset");

        // Randomized traffic
        rx_gap_max = 3;
        rd_mode    = 2;
        for (int i = 0; i < 150; i++)
            push_byte(($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                      8'($urandom_range(0, 255)));
        n = 0;
        while ((tx_q.size() != 0 || pend_q.size() != 0) && n < 3000) begin
            clear_status = ($urandom_range(0, 15) == 0);
            if (n % 200 == 100) rd_mode = 0;
            if (n % 200 == 160) rd_mode = 2;
            wait_cycles(1);
            n++;
        end
        clear_status = 1'b0;
        check("random_timeout", int'(n < 3000), 1);
        drain("drain_random");
        check("final_empty", count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
